// File: rtl/regfile32x32.sv
// 32 x 32-bit register file: two combinational read ports plus a debug read port,
// one synchronous write port, r0 hardwired to zero, and a committed-write counter.
module regfile32x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] d,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic [4:0]  dbg_n,
  output logic [31:0] dbg_q,
  output logic [15:0] wcount
);

  logic        wr_en;
  logic [31:0] rd_view [32];
  logic [15:0] wcount_d, wcount_q;

  // Writes to r0 are dropped and do not count as commits.
  assign wr_en = we && (wn != 5'd0);

  // Entry 0 is a constant, so r0 has no storage and always reads zero.
  assign rd_view[0] = 32'h0000_0000;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [31:0] r_d, r_q;

    always_comb begin
      r_d = r_q;
      if (wr_en && (wn == 5'(gi))) begin
        r_d = d;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else begin
        r_q <= r_d;
      end
    end

    assign rd_view[gi] = r_q;
  end

  always_comb begin
    wcount_d = wcount_q;
    if (wr_en) begin
      wcount_d = wcount_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcount_q <= '0;
    end else begin
      wcount_q <= wcount_d;
    end
  end

  // Reads come straight from storage: no write-to-read bypass, avoiding a loop through the ALU.
  assign qa     = rd_view[rna];
  assign qb     = rd_view[rnb];
  assign dbg_q  = rd_view[dbg_n];
  assign wcount = wcount_q;

endmodule

// File: tb/tb_regfile32x32.sv
// Self-checking bench for regfile32x32: directed scenarios, a vector table and a
// randomized run against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [4:0]  rna, rnb, dbg_n;
  logic [31:0] qa, qb, dbg_q;
  logic [15:0] wcount;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain array with r0 pinned to zero, and a wrapping counter.
  logic [31:0] mdl [32];
  logic [15:0] mcount;

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] exp_qa;
    logic [31:0] exp_qb;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t vecs [6];

  regfile32x32 dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wn     (wn),
    .d      (d),
    .rna    (rna),
    .rnb    (rnb),
    .qa     (qa),
    .qb     (qb),
    .dbg_n  (dbg_n),
    .dbg_q  (dbg_q),
    .wcount (wcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcount = '0;
  endtask

  task automatic model_write(input logic w, input logic [4:0] n, input logic [31:0] v);
    if (w && n != 5'd0) begin
      mdl[n] = v;
      mcount = mcount + 16'd1;
    end
  endtask

  // Present a write at the falling edge, commit on the next rising edge.
  task automatic apply(input logic w, input logic [4:0] n, input logic [31:0] v);
    @(negedge clk);
    we = w;
    wn = n;
    d  = v;
    @(posedge clk);
    model_write(w, n, v);
    #1;
    we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'h1234_5678, 5'd3,  5'd5,  32'h1234_5678, 32'hDEAD_BEEF, 16'd4};
    vecs[1] = '{1'b0, 5'd3,  32'hFFFF_FFFF, 5'd3,  5'd7,  32'h1234_5678, 32'h0000_0002, 16'd4};
    vecs[2] = '{1'b1, 5'd0,  32'hAAAA_AAAA, 5'd0,  5'd3,  32'h0000_0000, 32'h1234_5678, 16'd4};
    vecs[3] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd0,  32'h8000_0001, 32'h0000_0000, 16'd5};
    vecs[4] = '{1'b0, 5'd31, 32'hxxxx_xxxx, 5'd31, 5'd31, 32'h8000_0001, 32'h8000_0001, 16'd5};
    vecs[5] = '{1'b1, 5'd5,  32'h0000_0000, 5'd5,  5'd7,  32'h0000_0000, 32'h0000_0002, 16'd6};

    rst = 1'b1; we = 1'b0; wn = '0; d = '0; rna = 5'd1; rnb = 5'd17; dbg_n = 5'd31;
    model_clear();
    #2;
    check("reset_qa", qa, 32'h0);
    check("reset_qb", qb, 32'h0);
    check("reset_dbg", dbg_q, 32'h0);
    check("reset_wcount", {16'h0, wcount}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back.
    apply(1'b1, 5'd5, 32'hDEAD_BEEF);
    rna = 5'd5; #1;
    check("wr_rd_qa", qa, 32'hDEAD_BEEF);
    check("wr_rd_wcount", {16'h0, wcount}, 32'd1);

    // r0 protection.
    apply(1'b1, 5'd0, 32'hFFFF_FFFF);
    rna = 5'd0; #1;
    check("r0_qa", qa, 32'h0);
    check("r0_wcount", {16'h0, wcount}, 32'd1);

    // No bypass: old value before the edge, new value after.
    apply(1'b1, 5'd7, 32'd1);
    @(negedge clk);
    we = 1'b1; wn = 5'd7; d = 32'd2; rna = 5'd7;
    #1;
    check("nobypass_before", qa, 32'd1);
    @(posedge clk);
    model_write(1'b1, 5'd7, 32'd2);
    #1;
    we = 1'b0;
    check("nobypass_after", qa, 32'd2);

    for (int i = 0; i < 6; i++) begin
      apply(vecs[i].we, vecs[i].wn, vecs[i].d);
      rna = vecs[i].rna; rnb = vecs[i].rnb; #1;
      check($sformatf("vec%0d_qa", i), qa, vecs[i].exp_qa);
      check($sformatf("vec%0d_qb", i), qb, vecs[i].exp_qb);
      check($sformatf("vec%0d_wcount", i), {16'h0, wcount}, {16'h0, vecs[i].exp_wc});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      we    = 1'($urandom_range(0, 1));
      wn    = 5'($urandom);
      d     = $urandom;
      rna   = ($urandom_range(0, 2) == 0) ? wn : 5'($urandom);
      rnb   = 5'($urandom);
      dbg_n = 5'($urandom);
      #1;
      check("rand_pre_qa", qa, mdl[rna]);
      @(posedge clk);
      model_write(we, wn, d);
      #1;
      we = 1'b0;
      check("rand_qa", qa, mdl[rna]);
      check("rand_qb", qb, mdl[rnb]);
      check("rand_dbg", dbg_q, mdl[dbg_n]);
      check("rand_wcount", {16'h0, wcount}, {16'h0, mcount});
    end

    // Full sweep from a clean reset.
    do_reset();
    for (int i = 1; i < 32; i++) apply(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(i); dbg_n = 5'(i); #1;
      check($sformatf("sweep_qa%0d", i), qa, 32'(i) * 32'h0101_0101);
      check($sformatf("sweep_qb%0d", i), qb, mdl[i]);
      check($sformatf("sweep_dbg%0d", i), dbg_q, mdl[i]);
    end
    check("sweep_wcount", {16'h0, wcount}, 32'd31);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    rna = 5'd1; rnb = 5'd17; dbg_n = 5'd31; #1;
    check("async_qa", qa, 32'h0);
    check("async_qb", qb, 32'h0);
    check("async_dbg", dbg_q, 32'h0);
    check("async_wcount", {16'h0, wcount}, 32'h0);

    // Reset held across a write edge wins.
    @(negedge clk);
    we = 1'b1; wn = 5'd9; d = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    rna = 5'd9; #1;
    check("rst_wins_qa", qa, 32'h0);
    check("rst_wins_wcount", {16'h0, wcount}, 32'h0);
    @(negedge clk);
    we = 1'b0; rst = 1'b0;

    // First write after reset release is normal.
    apply(1'b1, 5'd9, 32'h0000_0055);
    #1;
    check("post_rst_qa", qa, 32'h0000_0055);
    check("post_rst_wcount", {16'h0, wcount}, {16'h0, mcount});

    // Counter wrap: 65534 more commits reach FFFF, one more wraps to 0.
    @(negedge clk);
    we = 1'b1; wn = 5'd1; d = 32'h1;
    repeat (65534) begin
      @(posedge clk);
      mcount = mcount + 16'd1;
    end
    #1;
    we = 1'b0;
    check("wrap_ffff", {16'h0, wcount}, 32'h0000_FFFF);
    apply(1'b1, 5'd2, 32'h2);
    #1;
    check("wrap_zero", {16'h0, wcount}, 32'h0);
    check("wrap_model", {16'h0, wcount}, {16'h0, mcount});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile32x32.md
REGFILE32X32 -- requirements
Module: regfile32x32

Interface
REQ-001 The block SHALL have no parameters: fixed at 32 registers x 32 bits, 5-bit addresses.
REQ-002 Port clk, input, 1 bit: single clock; all register writes occur on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port we, input, 1 bit: write enable, sampled on rising clk.
REQ-005 Port wn, input, 5 bits: write register number, driven by the destination-select mux (rd/rt).
REQ-006 Port d, input, 32 bits: write data.
REQ-007 Port rna, input, 5 bits: read port A register number.
REQ-008 Port rnb, input, 5 bits: read port B register number.
REQ-009 Port qa, output, 32 bits: read port A data.
REQ-010 Port qb, output, 32 bits: read port B data.
REQ-011 Port dbg_n, input, 5 bits: debug/monitor read register number.
REQ-012 Port dbg_q, output, 32 bits: debug read data.
REQ-013 Port wcount, output, 16 bits: count of committed writes to nonzero registers.

Function
REQ-014 The block SHALL store 31 writable 32-bit registers, r1..r31; r0 SHALL have no storage.
REQ-015 Reads on qa, qb and dbg_q SHALL be combinational from rna/rnb/dbg_n, with no clock latency.
REQ-016 Any read of register 0 SHALL return 32'h0000_0000 at all times.
REQ-017 On rising clk with rst=0, we=1 and wn!=0, register wn SHALL take d.
REQ-018 A write SHALL be visible on the read ports only after the capturing edge.
REQ-019 There SHALL be no write-to-read bypass: in the write cycle, a read of wn SHALL return the old value. This prevents a combinational loop through the ALU in the single-cycle datapath.
REQ-020 we=1 with wn=0 SHALL change no storage and SHALL NOT increment wcount.
REQ-021 we=0 SHALL change no storage regardless of wn and d.
REQ-022 wcount SHALL increment by 1 on each edge that commits a write per REQ-017.
REQ-023 wcount SHALL wrap from 16'hFFFF to 16'h0000 without saturation.
REQ-024 Reading the same register on qa, qb and dbg_q simultaneously SHALL return identical data.
REQ-025 X/Z on d with we=0 SHALL NOT propagate into storage.

Reset
REQ-026 When rst is asserted, r1..r31 and wcount SHALL clear to 0 immediately, independent of clk.
REQ-027 While rst=1, writes SHALL be blocked and all outputs SHALL read 0.
REQ-028 If rst asserts in the same cycle as a write, the reset SHALL win and the register SHALL read 0.
REQ-029 On rst deassertion, the first rising clk with we=1 SHALL perform a normal write.

Verification
REQ-030 Scenario, write then read back: rst pulse; write r5=32'hDEAD_BEEF; set rna=5 -> qa=DEADBEEF after the edge; wcount=1.
REQ-031 Scenario, r0 protection: we=1, wn=0, d=32'hFFFF_FFFF -> qa for rna=0 stays 0; wcount unchanged.
REQ-032 Scenario, no bypass: r7=1; same cycle we=1, wn=7, d=2, rna=7 -> qa=1 before the edge and 2 after it.
REQ-033 Scenario, full sweep: write r1..r31 with value=index*32'h0101_0101 -> both ports and dbg_q return the expected data for every index; wcount=31.
REQ-034 Scenario, async reset mid-operation: after REQ-033, assert rst between edges -> every read is 0 and wcount=0 before the next clk.
REQ-035 Scenario, counter wrap: force 65536 committed writes -> wcount returns to 0.
